// File: rtl/fwd_hazard_unit.sv
// Forwarding selects and pipeline hazard detection (load-use and multi-cycle unit) for the ID stage.
// Optional stall-cycle counter on STALL_CNT is built when FWD_STALL_CNT_EN is defined.
module fwd_hazard_unit #(
    parameter int AW     = 5,
    parameter int NSRC   = 2,
    parameter int MD_LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NSRC*AW-1:0]   ID_Src,
    input  logic [NSRC-1:0]      ID_SrcUsed,
    input  logic                 ID_IsMD,
    input  logic                 EX_RegW,
    input  logic                 EX_MemRd,
    input  logic [AW-1:0]        EX_RegRd,
    input  logic [AW-1:0]        MEM_RegRd,
    input  logic [AW-1:0]        WB_RegRd,
    input  logic                 MEM_RegW,
    input  logic                 WB_RegW,
    input  logic                 MD_Start,
    output logic [2*NSRC-1:0]    FORWARD_Out,
    output logic                 STALL,
    output logic                 FLUSH_EX,
    output logic                 MD_Busy
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [15:0]          STALL_CNT
`endif
);

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    md_state_e      state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [AW-1:0]  md_rd_q, md_rd_d;

    logic [AW-1:0]  src_s;
    logic           load_use_s;
    logic           md_dep_s;
    logic           hazard_s;

    // Per-channel forward select, EX over MEM over WB; address 0 is never forwarded.
    always_comb begin
        FORWARD_Out = '0;
        src_s       = '0;
        for (int i = 0; i < NSRC; i++) begin
            src_s = ID_Src[i*AW +: AW];
            if (rst || (src_s == '0)) begin
                FORWARD_Out[2*i +: 2] = 2'b00;
            end else if (EX_RegW && (EX_RegRd != '0) && (EX_RegRd == src_s)) begin
                FORWARD_Out[2*i +: 2] = 2'b10;
            end else if (MEM_RegW && (MEM_RegRd != '0) && (MEM_RegRd == src_s)) begin
                FORWARD_Out[2*i +: 2] = 2'b01;
            end else if (WB_RegW && (WB_RegRd != '0) && (WB_RegRd == src_s)) begin
                FORWARD_Out[2*i +: 2] = 2'b11;
            end else begin
                FORWARD_Out[2*i +: 2] = 2'b00;
            end
        end
    end

    // Dependencies of used source channels on the EX load and on the pending multi-cycle result.
    always_comb begin
        load_use_s = 1'b0;
        md_dep_s   = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (ID_SrcUsed[i]) begin
                if (EX_RegW && EX_MemRd && (EX_RegRd != '0) && (EX_RegRd == ID_Src[i*AW +: AW])) begin
                    load_use_s = 1'b1;
                end else begin
                    load_use_s = load_use_s;
                end
                if ((md_rd_q != '0) && (md_rd_q == ID_Src[i*AW +: AW])) begin
                    md_dep_s = 1'b1;
                end else begin
                    md_dep_s = md_dep_s;
                end
            end else begin
                load_use_s = load_use_s;
                md_dep_s   = md_dep_s;
            end
        end
    end

    assign MD_Busy  = (state_q == MD_BUSY);
    // rst gating keeps a load sitting in EX from stalling while the unit is held in reset.
    assign hazard_s = !rst && ((EX_RegW && EX_MemRd && load_use_s) || (MD_Busy && (ID_IsMD || md_dep_s)));
    assign STALL    = hazard_s;
    assign FLUSH_EX = hazard_s;

    // Multi-cycle unit next state: load latency on start, count down while busy, ignore restarts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        md_rd_d = md_rd_q;
        case (state_q)
            MD_IDLE: begin
                if (MD_Start) begin
                    state_d = MD_BUSY;
                    cnt_d   = 4'(MD_LAT - 1);
                    md_rd_d = EX_RegRd;
                end else begin
                    state_d = MD_IDLE;
                end
            end
            MD_BUSY: begin
                if (cnt_q == 4'd1) begin
                    state_d = MD_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = 4'd0;
                md_rd_d = '0;
            end
        endcase
    end

    // Multi-cycle unit state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= 4'd0;
            md_rd_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            md_rd_q <= md_rd_d;
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else if (STALL && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    assign STALL_CNT = stall_cnt_q;
`endif

endmodule
